// File: rtl/motor_pkg.sv
// Shared motor-control definitions: direction encoding, driver state
// encoding and the default widths shared with the PID stage.
package motor_pkg;

   localparam int unsigned MOTOR_CMD_WIDTH = 16;
   localparam int unsigned MOTOR_PWM_BITS  = 10;

   localparam logic DIR_FWD = 1'b0;
   localparam logic DIR_REV = 1'b1;

   typedef enum logic [1:0] {
      DRV_RUN  = 2'd0,
      DRV_DEAD = 2'd1,
      DRV_ARM  = 2'd2
   } drv_state_e;

endpackage

// File: rtl/pwm_cmd_convert.sv
// Signed two's-complement command to saturated sign-magnitude duty.
// Purely combinational; also used by the debug/UART readback path.
// A zero magnitude keeps the caller's current direction so that a
// zero command never requests a reversal.
module pwm_cmd_convert
   import motor_pkg::*;
#(
   parameter int unsigned CMD_WIDTH = MOTOR_CMD_WIDTH,
   parameter int unsigned PWM_BITS  = MOTOR_PWM_BITS
)(
   input  logic [CMD_WIDTH-1:0] cmd_i,
   input  logic                 cur_dir_i,
   output logic [PWM_BITS-1:0]  mag_o,
   output logic                 dir_o
);

   localparam int unsigned SHIFT = CMD_WIDTH - 1 - PWM_BITS;

   // One extra bit so the magnitude of the most negative command fits.
   logic [CMD_WIDTH:0] ext;
   logic [CMD_WIDTH:0] absval;
   logic [CMD_WIDTH:0] shifted;
   logic               sat;

   // Absolute value, scale down to PWM resolution, clamp to full scale.
   always_comb begin
      ext     = {cmd_i[CMD_WIDTH-1], cmd_i};
      absval  = cmd_i[CMD_WIDTH-1] ? -ext : ext;
      shifted = absval >> SHIFT;
      sat     = |shifted[CMD_WIDTH:PWM_BITS];
      mag_o   = sat ? '1 : shifted[PWM_BITS-1:0];
      dir_o   = (mag_o == '0) ? cur_dir_i : cmd_i[CMD_WIDTH-1];
   end

endmodule

// File: rtl/motor_pwm_driver.sv
// H-bridge PWM driver fed by the PID stage.
// Commands are latched into a shadow register and applied only at the
// period wrap; a direction reversal inserts a dead-time with the bridge
// off, then waits for the next wrap before driving again.
// Optional build macro: SLEW_LIMIT_EN limits the per-period duty change
// to SLEW_STEP (otherwise the shadow magnitude is loaded directly).
module motor_pwm_driver
   import motor_pkg::*;
#(
   parameter int unsigned CMD_WIDTH       = MOTOR_CMD_WIDTH,
   parameter int unsigned PWM_BITS        = MOTOR_PWM_BITS,
   parameter int unsigned DEADTIME_CYCLES = 32,
   parameter int unsigned SLEW_STEP       = 64
)(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 enable,
   input  logic [CMD_WIDTH-1:0] cmd_in,
   input  logic                 cmd_valid,
   output logic                 pwm_out,
   output logic                 dir_out,
   output logic                 period_start,
   output logic [PWM_BITS-1:0]  duty_active,
   output logic                 in_deadtime
);

   localparam logic [1:0] S_RUN  = DRV_RUN;
   localparam logic [1:0] S_DEAD = DRV_DEAD;
   localparam logic [1:0] S_ARM  = DRV_ARM;

   localparam logic [PWM_BITS-1:0] DEAD_LOAD = PWM_BITS'(DEADTIME_CYCLES);
   localparam logic [PWM_BITS-1:0] ONE       = PWM_BITS'(1);

   logic [PWM_BITS-1:0] cnt_q,   cnt_d;
   logic [PWM_BITS-1:0] duty_q,  duty_d;
   logic [PWM_BITS-1:0] shmag_q, shmag_d;
   logic [PWM_BITS-1:0] dead_q,  dead_d;
   logic [1:0]          state_q, state_d;
   logic                shdir_q, shdir_d;
   logic                dir_q,   dir_d;
   logic                pwm_q,   pwm_d;
   logic                ps_q,    ps_d;

   logic [PWM_BITS-1:0] conv_mag;
   logic                conv_dir;
   logic [PWM_BITS-1:0] wrap_duty;
   logic                wrap;

   assign wrap = (cnt_q == '1);

   pwm_cmd_convert #(
      .CMD_WIDTH (CMD_WIDTH),
      .PWM_BITS  (PWM_BITS)
   ) u_convert (
      .cmd_i     (cmd_in),
      .cur_dir_i (dir_q),
      .mag_o     (conv_mag),
      .dir_o     (conv_dir)
   );

`ifdef SLEW_LIMIT_EN
   localparam logic [PWM_BITS-1:0] STEP = PWM_BITS'(SLEW_STEP);

   // Duty for the next period: step toward the shadow target, clamping on arrival.
   always_comb begin
      if (shmag_q > duty_q) begin
         wrap_duty = ((shmag_q - duty_q) > STEP) ? duty_q + STEP : shmag_q;
      end else begin
         wrap_duty = ((duty_q - shmag_q) > STEP) ? duty_q - STEP : shmag_q;
      end
   end
`else
   // Duty for the next period: the shadow target as-is.
   always_comb begin
      wrap_duty = shmag_q;
   end
`endif

   // Counter, PWM compare, shadow capture and the RUN/DEAD/ARM sequencing.
   always_comb begin
      cnt_d   = cnt_q + ONE;
      ps_d    = (cnt_q == '0);
      pwm_d   = enable && (state_q == S_RUN) && (cnt_q < duty_q);

      shmag_d = shmag_q;
      shdir_d = shdir_q;
      if (cmd_valid) begin
         shmag_d = conv_mag;
         shdir_d = conv_dir;
      end

      duty_d  = duty_q;
      dir_d   = dir_q;
      dead_d  = dead_q;
      state_d = state_q;

      if (!enable) begin
         duty_d  = '0;
         dead_d  = '0;
         state_d = S_RUN;
      end else begin
         case (state_q)
            S_DEAD: begin
               // Leaving on the count of one gives exactly DEADTIME_CYCLES in DEAD.
               if (dead_q == ONE) begin
                  dir_d   = shdir_q;
                  dead_d  = '0;
                  state_d = S_ARM;
               end else begin
                  dead_d  = dead_q - ONE;
               end
            end
            default: begin
               // RUN and ARM take the same decision at the wrap.
               if (wrap) begin
                  if (shdir_q == dir_q) begin
                     duty_d  = wrap_duty;
                     state_d = S_RUN;
                  end else begin
                     duty_d  = '0;
                     dead_d  = DEAD_LOAD;
                     state_d = S_DEAD;
                  end
               end
            end
         endcase
      end
   end

   // State and output registers with synchronous active-high reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q   <= '0;
         duty_q  <= '0;
         shmag_q <= '0;
         dead_q  <= '0;
         state_q <= S_RUN;
         shdir_q <= DIR_FWD;
         dir_q   <= DIR_FWD;
         pwm_q   <= 1'b0;
         ps_q    <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         duty_q  <= duty_d;
         shmag_q <= shmag_d;
         dead_q  <= dead_d;
         state_q <= state_d;
         shdir_q <= shdir_d;
         dir_q   <= dir_d;
         pwm_q   <= pwm_d;
         ps_q    <= ps_d;
      end
   end

   assign pwm_out      = pwm_q;
   assign dir_out      = dir_q;
   assign period_start = ps_q;
   assign duty_active  = duty_q;
   assign in_deadtime  = (state_q == S_DEAD);

endmodule
